// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
//   Shared definitions for the UART receive controller: FSM state
//   encodings and parity-type constants.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        VALID  = 3'd5
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if
//   Bundle for the UART receive controller.
//   Towards the receiver: RX_IN (serial line), Prescale, PAR_EN, PAR_TYP, STOP2.
//   From the receiver:    P_DATA, data_valid, strt_glitch, par_err, stp_err.
//   master = line/config driver side, slave = receiver side.
interface uart_rx_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
);
    logic                  RX_IN;
    logic [PRESC_W-1:0]    Prescale;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  STOP2;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  strt_glitch;
    logic                  par_err;
    logic                  stp_err;

    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP, STOP2,
        input  P_DATA, data_valid, strt_glitch, par_err, stp_err
    );

    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP, STOP2,
        output P_DATA, data_valid, strt_glitch, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
//   Per-bit edge counter and 3-sample majority voter.
//   CLK, RST     : clock, synchronous active-high reset
//   en           : count enable; counter is held at 0 while low
//   prescale     : CLK cycles per bit (latched copy from the controller)
//   rx_in        : synchronised serial line
//   sampled_bit  : majority of the samples at prescale/2-1, /2, /2+1
//   bit_end      : high while the edge counter sits at prescale-1
module uart_rx_sampler #(
    parameter int PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               en,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               rx_in,
    output logic               sampled_bit,
    output logic               bit_end
);
    localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);

    logic [PRESC_W-1:0] edge_cnt;
    logic [PRESC_W-1:0] half;
    logic [PRESC_W-1:0] last;
    logic [1:0]         smp;

    assign half    = prescale >> 1;
    assign last    = prescale - ONE;
    assign bit_end = en && (edge_cnt == last);

    // Holding the counter at 0 whenever disabled, and wrapping it at the bit
    // end where every state change happens, gives the clear-on-entry behaviour.
    always_ff @(posedge CLK) begin
        if (RST || !en) begin
            edge_cnt <= '0;
        end else if (edge_cnt == last) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            smp         <= '0;
            sampled_bit <= 1'b0;
        end else if (en) begin
            if (edge_cnt == half - ONE) smp[0] <= rx_in;
            if (edge_cnt == half)       smp[1] <= rx_in;
            // Third sample is taken live and voted in the same cycle.
            if (edge_cnt == half + ONE) begin
                sampled_bit <= (smp[0] & smp[1]) | (smp[0] & rx_in) | (smp[1] & rx_in);
            end
        end
    end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
//   UART receive controller: start detect, data shift-in, optional parity,
//   one or two stop bits, registered result and error pulses.
//   CLK  : clock
//   RST  : synchronous active-high reset
//   bus  : uart_rx_ctrl_if.slave
//          in : RX_IN, Prescale, PAR_EN, PAR_TYP, STOP2
//          out: P_DATA, data_valid, strt_glitch, par_err, stp_err (all registered)
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic           CLK,
    input  logic           RST,
    uart_rx_ctrl_if.slave  bus
);
    localparam int BCW = $clog2(DATA_WIDTH + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);
    localparam logic [BCW-1:0] BC_ONE   = BCW'(1);

    rx_state_e             state;
    logic [PRESC_W-1:0]    presc_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  stop2_q;
    logic [BCW-1:0]        bit_cnt;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  smp_en;
    logic                  smp_bit;
    logic                  bit_end;
    logic                  exp_par;

    assign smp_en  = (state != IDLE) && (state != VALID);
    assign exp_par = (^shift_q) ^ (par_typ_q == PAR_ODD);

    uart_rx_sampler #(
        .PRESC_W(PRESC_W)
    ) u_sampler (
        .CLK         (CLK),
        .RST         (RST),
        .en          (smp_en),
        .prescale    (presc_q),
        .rx_in       (bus.RX_IN),
        .sampled_bit (smp_bit),
        .bit_end     (bit_end)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state           <= IDLE;
            presc_q         <= '0;
            par_en_q        <= 1'b0;
            par_typ_q       <= PAR_EVEN;
            stop2_q         <= 1'b0;
            bit_cnt         <= '0;
            shift_q         <= '0;
            bus.P_DATA      <= '0;
            bus.data_valid  <= 1'b0;
            bus.strt_glitch <= 1'b0;
            bus.par_err     <= 1'b0;
            bus.stp_err     <= 1'b0;
        end else begin
            bus.data_valid  <= 1'b0;
            bus.strt_glitch <= 1'b0;
            bus.par_err     <= 1'b0;
            bus.stp_err     <= 1'b0;

            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (!bus.RX_IN) begin
                        presc_q   <= bus.Prescale;
                        par_en_q  <= bus.PAR_EN;
                        par_typ_q <= bus.PAR_TYP;
                        stop2_q   <= bus.STOP2;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        if (!smp_bit) begin
                            state <= DATA;
                        end else begin
                            bus.strt_glitch <= 1'b1;
                            state           <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift_q <= {smp_bit, shift_q[DATA_WIDTH-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BC_ONE;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        if (smp_bit != exp_par) begin
                            bus.par_err <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    // bit_cnt is reused here as the stop-bit index.
                    if (bit_end) begin
                        if (!smp_bit) begin
                            bus.stp_err <= 1'b1;
                            state       <= IDLE;
                        end else if (stop2_q && (bit_cnt == '0)) begin
                            bit_cnt <= BC_ONE;
                        end else begin
                            bit_cnt        <= '0;
                            bus.P_DATA     <= shift_q;
                            bus.data_valid <= 1'b1;
                            state          <= VALID;
                        end
                    end
                end
                VALID: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl
//   Directed bench for uart_rx_ctrl: an 8-bit instance for single frames,
//   errors and reset, and a 5-bit instance for back-to-back frames.
module tb_uart_rx_ctrl;
    import uart_rx_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    uart_rx_ctrl_if #(.DATA_WIDTH(8), .PRESC_W(6)) b8 ();
    uart_rx_ctrl_if #(.DATA_WIDTH(5), .PRESC_W(6)) b5 ();

    uart_rx_ctrl #(.DATA_WIDTH(8), .PRESC_W(6)) dut8 (.CLK(CLK), .RST(RST), .bus(b8));
    uart_rx_ctrl #(.DATA_WIDTH(5), .PRESC_W(6)) dut5 (.CLK(CLK), .RST(RST), .bus(b5));

    // Pulse monitors, sampled away from the active edge.
    int         dv8_cnt = 0, gl8_cnt = 0, pe8_cnt = 0, se8_cnt = 0;
    int         dv8_cyc = 0, gl8_cyc = 0, pe8_cyc = 0, se8_cyc = 0;
    logic [7:0] dv8_data = '0;
    int         dv5_cnt = 0, err5_cnt = 0;
    int         dv5_cyc [0:3];
    logic [4:0] dv5_data [0:3];
    int         ovl_cnt = 0;

    always @(negedge CLK) begin
        if (b8.data_valid)  begin dv8_cnt++; dv8_cyc = cyc; dv8_data = b8.P_DATA; end
        if (b8.strt_glitch) begin gl8_cnt++; gl8_cyc = cyc; end
        if (b8.par_err)     begin pe8_cnt++; pe8_cyc = cyc; end
        if (b8.stp_err)     begin se8_cnt++; se8_cyc = cyc; end
        if (b5.data_valid) begin
            if (dv5_cnt < 4) begin
                dv5_cyc[dv5_cnt]  = cyc;
                dv5_data[dv5_cnt] = b5.P_DATA;
            end
            dv5_cnt++;
        end
        if (b5.strt_glitch || b5.par_err || b5.stp_err) err5_cnt++;
        if ((int'(b8.data_valid) + int'(b8.strt_glitch) + int'(b8.par_err) + int'(b8.stp_err)) > 1) ovl_cnt++;
        if ((int'(b5.data_valid) + int'(b5.strt_glitch) + int'(b5.par_err) + int'(b5.stp_err)) > 1) ovl_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input int sel, input logic v, input int p);
        if (sel == 0) b8.RX_IN = v; else b5.RX_IN = v;
        repeat (p) @(posedge CLK);
        #1;
    endtask

    // Drives one frame starting now; line is returned high at the end.
    task automatic send_frame(input int sel, input logic [8:0] data, input int nbits, input int p,
                              input logic par_en, input logic par_bit,
                              input int nstop, input logic [1:0] stop_v);
        drive_bit(sel, 1'b0, p);
        for (int i = 0; i < nbits; i++) drive_bit(sel, data[i], p);
        if (par_en) drive_bit(sel, par_bit, p);
        for (int i = 0; i < nstop; i++) drive_bit(sel, stop_v[i], p);
        if (sel == 0) b8.RX_IN = 1'b1; else b5.RX_IN = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    int c0;

    initial begin
        b8.RX_IN = 1'b1; b8.Prescale = 6'd8; b8.PAR_EN = 1'b0; b8.PAR_TYP = 1'b0; b8.STOP2 = 1'b0;
        b5.RX_IN = 1'b1; b5.Prescale = 6'd16; b5.PAR_EN = 1'b1; b5.PAR_TYP = 1'b1; b5.STOP2 = 1'b0;

        // Reset state
        idle(3);
        check("rst_pdata",  32'(b8.P_DATA), 32'h0);
        check("rst_dv",     32'(b8.data_valid), 32'h0);
        check("rst_errs",   32'({b8.strt_glitch, b8.par_err, b8.stp_err}), 32'h0);
        check("rst_state",  32'(dut8.state), 32'(IDLE));
        RST = 1'b0;
        idle(4);

        // 0xA5, P=8, no parity, one stop: latency 1+8*10 = 81
        c0 = cyc;
        send_frame(0, 9'h0A5, 8, 8, 1'b0, 1'b0, 1, 2'b11);
        idle(6);
        check("a5_dv_cnt",  32'(dv8_cnt), 32'd1);
        check("a5_data",    32'(dv8_data), 32'hA5);
        check("a5_latency", 32'(dv8_cyc - c0), 32'd81);
        check("a5_pdata",   32'(b8.P_DATA), 32'hA5);

        // 0x3C, P=16, even parity, wrong parity bit 1: par_err at 1+16*10 = 161
        b8.Prescale = 6'd16; b8.PAR_EN = 1'b1; b8.PAR_TYP = PAR_EVEN;
        c0 = cyc;
        send_frame(0, 9'h03C, 8, 16, 1'b1, 1'b1, 1, 2'b11);
        idle(6);
        check("par_cnt",    32'(pe8_cnt), 32'd1);
        check("par_time",   32'(pe8_cyc - c0), 32'd161);
        check("par_no_dv",  32'(dv8_cnt), 32'd1);
        check("par_pdata",  32'(b8.P_DATA), 32'hA5);

        // Start glitch: low 3 cycles at P=8, pulse at edge count 7 -> cycle 9
        b8.Prescale = 6'd8; b8.PAR_EN = 1'b0;
        c0 = cyc;
        b8.RX_IN = 1'b0;
        idle(3);
        b8.RX_IN = 1'b1;
        idle(10);
        check("gl_cnt",     32'(gl8_cnt), 32'd1);
        check("gl_time",    32'(gl8_cyc - c0), 32'd9);
        check("gl_state",   32'(dut8.state), 32'(IDLE));
        check("gl_no_dv",   32'(dv8_cnt), 32'd1);

        // Two stop bits, second one 0, data 0x55: stp_err at 1+8*11 = 89
        b8.STOP2 = 1'b1;
        c0 = cyc;
        send_frame(0, 9'h055, 8, 8, 1'b0, 1'b0, 2, 2'b01);
        idle(6);
        check("stp_cnt",    32'(se8_cnt), 32'd1);
        check("stp_time",   32'(se8_cyc - c0), 32'd89);
        check("stp_no_dv",  32'(dv8_cnt), 32'd1);
        check("stp_pdata",  32'(b8.P_DATA), 32'hA5);

        // Clean 0x0F with two stop bits, config changed mid-frame
        c0 = cyc;
        fork
            send_frame(0, 9'h00F, 8, 8, 1'b0, 1'b0, 2, 2'b11);
            begin
                idle(20);
                b8.Prescale = 6'd16; b8.STOP2 = 1'b0; b8.PAR_EN = 1'b1;
            end
        join
        idle(6);
        b8.Prescale = 6'd8; b8.STOP2 = 1'b0; b8.PAR_EN = 1'b0;
        check("0f_dv_cnt",  32'(dv8_cnt), 32'd2);
        check("0f_data",    32'(dv8_data), 32'h0F);
        check("0f_latency", 32'(dv8_cyc - c0), 32'd89);

        // Reset mid-DATA, then 0x81
        drive_bit(0, 1'b0, 8);
        drive_bit(0, 1'b1, 8);
        drive_bit(0, 1'b0, 8);
        drive_bit(0, 1'b1, 8);
        RST = 1'b1; b8.RX_IN = 1'b1;
        idle(1);
        RST = 1'b0;
        check("mrst_pdata", 32'(b8.P_DATA), 32'h0);
        check("mrst_outs",  32'({b8.data_valid, b8.strt_glitch, b8.par_err, b8.stp_err}), 32'h0);
        check("mrst_state", 32'(dut8.state), 32'(IDLE));
        idle(20);
        c0 = cyc;
        send_frame(0, 9'h081, 8, 8, 1'b0, 1'b0, 1, 2'b11);
        idle(6);
        check("81_dv_cnt",  32'(dv8_cnt), 32'd3);
        check("81_data",    32'(dv8_data), 32'h81);
        check("81_latency", 32'(dv8_cyc - c0), 32'd81);
        check("errs_total", 32'({8'(gl8_cnt), 8'(pe8_cnt), 8'(se8_cnt)}), 32'h010101);

        // 5-bit, odd parity, back-to-back 0x1F (par 0) and 0x00 (par 1), P=16
        c0 = cyc;
        send_frame(1, 9'h01F, 5, 16, 1'b1, 1'b0, 1, 2'b11);
        send_frame(1, 9'h000, 5, 16, 1'b1, 1'b1, 1, 2'b11);
        idle(40);
        check("b2b_dv_cnt", 32'(dv5_cnt), 32'd2);
        check("b2b_d0",     32'(dv5_data[0]), 32'h1F);
        check("b2b_t0",     32'(dv5_cyc[0] - c0), 32'd129);
        check("b2b_d1",     32'(dv5_data[1]), 32'h00);
        check("b2b_t1",     32'(dv5_cyc[1] - c0), 32'd259);
        check("b2b_errs",   32'(err5_cnt), 32'd0);
        check("b2b_pdata",  32'(b5.P_DATA), 32'h00);

        check("pulse_excl", 32'(ovl_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
